wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Writeback arbiter that drives the register file's single write port (enable, destination, data).
- Merges two producers into one registered write per cycle: the ALU (single-cycle results) and the LSU (load results, buffered in a small FIFO).
- Exports a pending-write mask so decode can stall on RAW hazards against writes not yet committed.

Parameters:
XLEN, 64, data width of results and write port
LSU_DEPTH, 4, LSU result FIFO entries; power of 2, >= 2
STARVE_LIMIT, 3, cycles a waiting LSU head may lose arbitration before it is forced to win

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
alu_valid_i  input  1  ALU result valid
alu_ready_o  output  1  ALU result accepted when valid&&ready
alu_dest_i  input  5  ALU destination register
alu_data_i  input  XLEN  ALU result
lsu_valid_i  input  1  load result valid
lsu_ready_o  output  1  LSU FIFO can accept
lsu_dest_i  input  5  load destination register
lsu_data_i  input  XLEN  load data
wr_reg_en_o  output  1  register file write enable
wr_reg_dest_o  output  5  register file write destination
wr_reg_data_o  output  XLEN  register file write data
pending_o  output  32  bit r=1 if a write to r is buffered or in the output register; bit 0 always 0

Behaviour:
- Reset (async, rst_ni=0): FIFO count, pointers and starve_cnt cleared. wr_reg_en_o=0, wr_reg_dest_o=0, wr_reg_data_o=0, pending_o=0. Buffered entries are discarded and never written.
- Reset mid-operation takes effect immediately without waiting for a clock edge.
- LSU FIFO:
  - lsu_ready_o = (count < LSU_DEPTH), computed from current count only.
  - When full, a same-cycle pop does not allow a push.
  - Push on lsu_valid_i && lsu_ready_o.
  - A pushed entry is not eligible for arbitration in its push cycle (no bypass).
  - Pointers wrap modulo LSU_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
- Arbitration, evaluated each cycle:
  - force = (count>0) && (starve_cnt >= STARVE_LIMIT).
  - alu_ready_o = !force.
  - If alu_valid_i && alu_ready_o: grant the ALU.
  - Else if count>0: grant the FIFO head (pop).
  - Else: no grant.
- starve_cnt:
  - Cleared when the head pops or the FIFO is empty.
  - Otherwise increments when count>0 and the head was not granted.
  - Saturates at STARVE_LIMIT.
- Output register, updated every cycle:
  - On grant: wr_reg_en_o <= (dest != 0); wr_reg_dest_o, wr_reg_data_o <= granted dest/data.
  - On no grant: wr_reg_en_o <= 0; dest/data hold their previous values.
  - Dest 0 results are consumed but never written.
- Latency:
  - ALU accepted in cycle N: write visible N+1.
  - LSU pushed in cycle N into an empty FIFO with the ALU idle: write visible N+2.
- pending_o: combinational OR of one-hot(dest) over valid FIFO entries and over the output register when wr_reg_en_o=1; bit 0 forced 0.
- Ordering: no ordering between the ALU and LSU streams is enforced here. Decode must stall issue to any register whose pending_o bit is 1.
- LSU entries leave strictly in FIFO order.

Test Plan:
- Reset: rst_ni=0 with 2 FIFO entries buffered -> same cycle: pending_o=0, wr_reg_en_o=0. After release: lsu_ready_o=1, alu_ready_o=1, no writes for buffered entries.
- ALU path:
  - alu_valid_i=1, dest=5, data=0xAAAA in cycle N -> cycle N+1: wr_reg_en_o=1, wr_reg_dest_o=5, wr_reg_data_o=0xAAAA.
  - dest=0 -> wr_reg_en_o=0.
- LSU path: push dest=7, data=0x1234 in cycle N, ALU idle -> pending_o[7]=1 at N+1, write at N+2, pending_o[7]=0 at N+3.
- Full FIFO: ALU valid every cycle, push 4 LSU entries -> lsu_ready_o=0 after the 4th push. Further lsu_valid_i is held, not lost.
- Starvation: LSU head waiting while ALU stays valid -> after 3 losses, alu_ready_o=0 for one cycle, head written, starve_cnt=0, ALU then resumes winning.
- Simultaneous push/pop at count=2 -> count stays 2; write order matches push order for 8 back-to-back loads.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered load results
// into one registered register-file write port, with a pending-write mask.
module wb_arbiter #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned LSU_DEPTH    = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  logic [4:0]      alu_dest_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic [4:0]      lsu_dest_i,
    input  logic [XLEN-1:0] lsu_data_i,
    output logic            wr_reg_en_o,
    output logic [4:0]      wr_reg_dest_o,
    output logic [XLEN-1:0] wr_reg_data_o,
    output logic [31:0]     pending_o
);

    localparam int unsigned PW = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
    localparam int unsigned CW = $clog2(LSU_DEPTH + 1);
    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [4:0]           fifo_dest [LSU_DEPTH];
    logic [XLEN-1:0]      fifo_data [LSU_DEPTH];
    logic [LSU_DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]        rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        starve_q, starve_d;

    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_dest_q, wr_dest_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;

    logic not_empty, force_head, alu_gnt, pop, push;

    assign not_empty   = (cnt_q != '0);
    assign force_head  = not_empty && (starve_q >= SW'(STARVE_LIMIT));
    assign alu_ready_o = !force_head;
    assign lsu_ready_o = (cnt_q < CW'(LSU_DEPTH));
    assign alu_gnt     = alu_valid_i && !force_head;
    // Head only competes with entries already stored: no same-cycle bypass.
    assign pop         = !alu_gnt && not_empty;
    assign push        = lsu_valid_i && lsu_ready_o;

    always_comb begin
        wr_en_d   = 1'b0;
        wr_dest_d = wr_dest_q;
        wr_data_d = wr_data_q;
        if (alu_gnt) begin
            wr_en_d   = (alu_dest_i != 5'd0);
            wr_dest_d = alu_dest_i;
            wr_data_d = alu_data_i;
        end else if (pop) begin
            wr_en_d   = (fifo_dest[rd_q] != 5'd0);
            wr_dest_d = fifo_dest[rd_q];
            wr_data_d = fifo_data[rd_q];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        rd_d  = pop  ? rd_q + PW'(1) : rd_q;
        wr_d  = push ? wr_q + PW'(1) : wr_q;
        vld_d = vld_q;
        if (pop)  vld_d[rd_q] = 1'b0;
        if (push) vld_d[wr_q] = 1'b1;
    end

    always_comb begin
        starve_d = starve_q;
        if (pop || !not_empty) begin
            starve_d = '0;
        end else if (starve_q < SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
        end else begin
            vld_q     <= vld_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_dest_q <= wr_dest_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_dest[wr_q] <= lsu_dest_i;
            fifo_data[wr_q] <= lsu_data_i;
        end
    end

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < int'(LSU_DEPTH); i++) begin
            if (vld_q[i]) pending_o[fifo_dest[i]] = 1'b1;
        end
        if (wr_en_q) pending_o[wr_dest_q] = 1'b1;
        pending_o[0] = 1'b0;
    end

    assign wr_reg_en_o   = wr_en_q;
    assign wr_reg_dest_o = wr_dest_q;
    assign wr_reg_data_o = wr_data_q;

endmodule
